// File: rtl/synth_audio_pkg.sv
// rtl/synth_audio_pkg.sv - shared sample type and audio timing constants
// Contents: sample_t (16-bit signed sample), and the default I2S frame timing
// for a 96 MHz system clock: 2000 clocks per 48 kHz frame, 25-clock BCLK
// half-period, 20-bit channel slots and a 4-clock MCLK half-period (12 MHz).
package synth_audio_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int CLKS_PER_FRAME = 2000;
    localparam int BCLK_HALF      = 25;
    localparam int SLOT_BITS      = 20;
    localparam int MCLK_HALF      = 4;

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - I2S frame counter and mclk/bclk/lrclk generation
// Ports:
//   clk96M, reset_n        : system clock, asynchronous active-low reset
//   mclk, bclk, lrclk      : registered codec clocks, pure functions of the frame counter
//   frame_start            : the coming edge wraps the counter to 0 (frame load edge)
//   bit_fall               : the coming edge is a BCLK falling edge
//   bit_idx                : bit index k (0..2*SLOT_BITS-1) valid from the coming edge
// The strobes describe the next edge so the top level can update sdata and
// the hold register on the same edge the counter takes its new value.
module i2s_clkgen
    import synth_audio_pkg::*;
#(
    parameter int CLKS_PER_FRAME = synth_audio_pkg::CLKS_PER_FRAME,
    parameter int BCLK_HALF      = synth_audio_pkg::BCLK_HALF,
    parameter int SLOT_BITS      = synth_audio_pkg::SLOT_BITS,
    parameter int MCLK_HALF      = synth_audio_pkg::MCLK_HALF,
    parameter int KW             = $clog2(2 * SLOT_BITS)
) (
    input  logic          clk96M,
    input  logic          reset_n,
    output logic          mclk,
    output logic          bclk,
    output logic          lrclk,
    output logic          frame_start,
    output logic          bit_fall,
    output logic [KW-1:0] bit_idx
);

    localparam int CW = $clog2(CLKS_PER_FRAME);
    localparam int HW = $clog2(BCLK_HALF + 1);
    localparam int MW = $clog2(MCLK_HALF + 1);

    logic [CW-1:0] c;
    logic [HW-1:0] hcnt;
    logic [MW-1:0] mcnt;
    logic [KW-1:0] k;
    logic          half_end;
    logic          mclk_end;

    always_comb begin
        frame_start = (c == CW'(CLKS_PER_FRAME - 1));
        half_end    = (hcnt == HW'(BCLK_HALF - 1));
        mclk_end    = (mcnt == MW'(MCLK_HALF - 1));
        // The wrap edge is always a BCLK fall: the frame holds an even
        // number of BCLK half-periods, so bclk is high just before it.
        bit_fall    = frame_start || (half_end && bclk);
        if (frame_start) begin
            bit_idx = '0;
        end else if (bit_fall) begin
            bit_idx = k + KW'(1);
        end else begin
            bit_idx = k;
        end
    end

    // Sub-counters are cleared on wrap so every output stays a strict
    // function of c even if MCLK does not divide the frame evenly.
    always_ff @(posedge clk96M or negedge reset_n) begin
        if (!reset_n) begin
            c     <= '0;
            hcnt  <= '0;
            mcnt  <= '0;
            k     <= '0;
            mclk  <= 1'b0;
            bclk  <= 1'b0;
            lrclk <= 1'b0;
        end else begin
            c     <= frame_start ? '0 : c + CW'(1);
            hcnt  <= (frame_start || half_end) ? '0 : hcnt + HW'(1);
            mcnt  <= (frame_start || mclk_end) ? '0 : mcnt + MW'(1);
            bclk  <= frame_start ? 1'b0 : (half_end ? ~bclk : bclk);
            mclk  <= frame_start ? 1'b0 : (mclk_end ? ~mclk : mclk);
            k     <= bit_idx;
            lrclk <= (bit_idx >= KW'(SLOT_BITS));
        end
    end

endmodule

// File: rtl/i2s_codec_tx.sv
// rtl/i2s_codec_tx.sv - I2S master transmitter for the SSM2603 codec
// Ports:
//   clk96M, reset_n        : 96 MHz clock, asynchronous active-low reset
//   din, din_valid         : mono sample stream from the generator
//   din_ready              : 1-entry buffer is empty
//   mclk, bclk, lrclk      : codec clocks (12 MHz, 1.92 MHz, 48 kHz)
//   sdata                  : I2S data, MSB one BCLK after the LRCLK edge, same sample on both channels
//   frame_tick             : pulse when a frame loads its sample
//   underrun               : pulse when a frame loads with the buffer empty
module i2s_codec_tx
    import synth_audio_pkg::*;
#(
    parameter int DW             = $bits(sample_t),
    parameter int CLKS_PER_FRAME = synth_audio_pkg::CLKS_PER_FRAME,
    parameter int BCLK_HALF      = synth_audio_pkg::BCLK_HALF,
    parameter int SLOT_BITS      = synth_audio_pkg::SLOT_BITS,
    parameter int MCLK_HALF      = synth_audio_pkg::MCLK_HALF
) (
    input  logic          clk96M,
    input  logic          reset_n,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          mclk,
    output logic          bclk,
    output logic          lrclk,
    output logic          sdata,
    output logic          frame_tick,
    output logic          underrun
);

    localparam int KW = $clog2(2 * SLOT_BITS);

    logic          frame_start;
    logic          bit_fall;
    logic [KW-1:0] bit_idx;

    logic [DW-1:0] buf_q;
    logic          buf_full;
    logic [DW-1:0] hold_q;
    logic          accept;
    logic          full_next;
    logic          bit_val;
    int            pos;

    i2s_clkgen #(
        .CLKS_PER_FRAME (CLKS_PER_FRAME),
        .BCLK_HALF      (BCLK_HALF),
        .SLOT_BITS      (SLOT_BITS),
        .MCLK_HALF      (MCLK_HALF),
        .KW             (KW)
    ) u_clkgen (
        .clk96M      (clk96M),
        .reset_n     (reset_n),
        .mclk        (mclk),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .frame_start (frame_start),
        .bit_fall    (bit_fall),
        .bit_idx     (bit_idx)
    );

    always_comb begin
        accept = din_valid && din_ready;
        // A load empties the buffer; a write in the same cycle refills it.
        full_next = (buf_full && !frame_start) || accept;

        // Slot position p: 0 is the idle bit after the LRCLK edge, 1..DW
        // carry MSB..LSB, the rest of the slot is zero padding.
        pos = int'(bit_idx);
        if (pos >= SLOT_BITS) begin
            pos = pos - SLOT_BITS;
        end
        bit_val = 1'b0;
        if (pos >= 1 && pos <= DW) begin
            bit_val = |(hold_q & (DW'(1) << (DW - pos)));
        end
    end

    // hold_q only changes on the wrap edge, where the slot position is 0,
    // so sdata never mixes bits from two samples.
    always_ff @(posedge clk96M or negedge reset_n) begin
        if (!reset_n) begin
            buf_q      <= '0;
            buf_full   <= 1'b0;
            hold_q     <= '0;
            din_ready  <= 1'b1;
            sdata      <= 1'b0;
            frame_tick <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_tick <= frame_start;
            underrun   <= frame_start && !buf_full;
            if (frame_start && buf_full) begin
                hold_q <= buf_q;
            end
            if (accept) begin
                buf_q <= din;
            end
            buf_full  <= full_next;
            din_ready <= !full_next;
            if (bit_fall) begin
                sdata <= bit_val;
            end
        end
    end

endmodule

// File: tb/tb_i2s_codec_tx.sv
// tb/tb_i2s_codec_tx.sv - self-checking bench for i2s_codec_tx
module tb_i2s_codec_tx;

    localparam int FRAME = 2000;

    logic        clk96M    = 1'b0;
    logic        reset_n   = 1'b0;
    logic [15:0] din       = 16'h0000;
    logic        din_valid = 1'b0;
    logic        din_ready, mclk, bclk, lrclk, sdata, frame_tick, underrun;

    int errors = 0;
    int checks = 0;

    i2s_codec_tx dut (
        .clk96M     (clk96M),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .mclk       (mclk),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .frame_tick (frame_tick),
        .underrun   (underrun)
    );

    always #5 clk96M = ~clk96M;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: cycle position in the frame, the 1-entry buffer and the held sample.
    int          mc     = 0;
    logic        m_full = 1'b0;
    logic [15:0] m_buf  = 16'h0;
    logic [15:0] m_hold = 16'h0;
    logic        m_tick = 1'b0;
    logic        m_under = 1'b0;

    always @(posedge clk96M or negedge reset_n) begin
        if (!reset_n) begin
            mc <= 0; m_full <= 1'b0; m_buf <= '0; m_hold <= '0;
            m_tick <= 1'b0; m_under <= 1'b0;
        end else begin
            m_tick  <= (mc == FRAME - 1);
            m_under <= (mc == FRAME - 1) && !m_full;
            if (mc == FRAME - 1 && m_full) m_hold <= m_buf;
            if (din_valid && !m_full) m_buf <= din;
            m_full <= (m_full && mc != FRAME - 1) || (din_valid && !m_full);
            mc <= (mc + 1) % FRAME;
        end
    end

    // Outputs follow directly from c: clocks by division, data from slot position.
    int   ek, ep;
    logic exp_sd;
    always @(negedge clk96M) begin
        ek = mc / 50;
        ep = ek % 20;
        exp_sd = (ep >= 1 && ep <= 16) ? m_hold[16 - ep] : 1'b0;
        chk("mclk",       32'(mclk),       32'((mc / 4) % 2));
        chk("bclk",       32'(bclk),       32'((mc / 25) % 2));
        chk("lrclk",      32'(lrclk),      32'(mc >= 1000));
        chk("sdata",      32'(sdata),      32'(exp_sd));
        chk("din_ready",  32'(din_ready),  32'(!m_full));
        chk("frame_tick", 32'(frame_tick), 32'(m_tick));
        chk("underrun",   32'(underrun),   32'(m_under));
    end

    task automatic wait_c(input int target);
        int n = 0;
        do begin
            @(negedge clk96M);
            n++;
        end while (mc != target && n < 5000);
        if (mc != target) chk("wait_c_timeout", 32'(mc), 32'(target));
    endtask

    task automatic send(input logic [15:0] v);
        int n = 0;
        @(negedge clk96M);
        while (!din_ready && n < 5000) begin
            @(negedge clk96M);
            n++;
        end
        if (!din_ready) chk("send_timeout", 32'(din_ready), 32'd1);
        din = v;
        din_valid = 1'b1;
        @(negedge clk96M);
        din_valid = 1'b0;
    endtask

    task automatic capture_cur(output logic [15:0] l, output logic [15:0] r);
        l = '0;
        r = '0;
        for (int k = 0; k < 40; k++) begin
            wait_c(50 * k + 25);
            if (k >= 1 && k <= 16) l = {l[14:0], sdata};
            if (k >= 21 && k <= 36) r = {r[14:0], sdata};
        end
    endtask

    task automatic capture_next(output logic [15:0] l, output logic [15:0] r, output logic u);
        wait_c(0);
        u = underrun;
        capture_cur(l, r);
    endtask

    logic [15:0] left, right;
    logic        und;
    logic        p_m, p_b, p_l;
    int          n_m, n_b, n_l, n_u, n_t, n_s;

    initial begin
        // reset and idle frames
        repeat (3) @(negedge clk96M);
        chk("rst_ready", 32'(din_ready), 32'd1);
        chk("rst_bclk", 32'(bclk), 32'd0);
        chk("rst_sdata", 32'(sdata), 32'd0);
        reset_n = 1'b1;
        p_m = mclk; p_b = bclk; p_l = lrclk;
        n_m = 0; n_b = 0; n_l = 0; n_u = 0; n_t = 0; n_s = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk96M);
            if (mclk && !p_m) n_m++;
            if (bclk && !p_b) n_b++;
            if (lrclk && !p_l) n_l++;
            if (underrun) n_u++;
            if (frame_tick) n_t++;
            if (sdata) n_s++;
            p_m = mclk; p_b = bclk; p_l = lrclk;
        end
        chk("idle_mclk_rises", 32'(n_m), 32'd750);
        chk("idle_bclk_rises", 32'(n_b), 32'd120);
        chk("idle_lrclk_rises", 32'(n_l), 32'd3);
        chk("idle_underruns", 32'(n_u), 32'd3);
        chk("idle_ticks", 32'(n_t), 32'd3);
        chk("idle_sdata_high", 32'(n_s), 32'd0);

        // single sample A5C3
        wait_c(100);
        send(16'hA5C3);
        capture_next(left, right, und);
        chk("a5c3_left", 32'(left), 32'h0000A5C3);
        chk("a5c3_right", 32'(right), 32'h0000A5C3);
        chk("a5c3_underrun", 32'(und), 32'd0);

        // 8001 then starve: repeated with underrun
        send(16'h8001);
        capture_next(left, right, und);
        chk("8001_f1_left", 32'(left), 32'h00008001);
        chk("8001_f1_underrun", 32'(und), 32'd0);
        capture_next(left, right, und);
        chk("8001_f2_left", 32'(left), 32'h00008001);
        chk("8001_f2_right", 32'(right), 32'h00008001);
        chk("8001_f2_underrun", 32'(und), 32'd1);

        // back-to-back writes, second stalls until the frame load
        wait_c(200);
        send(16'h1111);
        din = 16'h2222;
        din_valid = 1'b1;
        chk("b2b_stall", 32'(din_ready), 32'd0);
        wait_c(1999);
        chk("b2b_stall_end", 32'(din_ready), 32'd0);
        @(negedge clk96M);
        chk("b2b_ready_at_c0", 32'(din_ready), 32'd1);
        chk("b2b_tick", 32'(frame_tick), 32'd1);
        @(negedge clk96M);
        din_valid = 1'b0;
        chk("b2b_full_again", 32'(din_ready), 32'd0);
        capture_cur(left, right);
        chk("b2b_first", 32'(left), 32'h00001111);
        capture_next(left, right, und);
        chk("b2b_second", 32'(left), 32'h00002222);
        chk("b2b_second_underrun", 32'(und), 32'd0);

        // write on the wrap edge with the buffer empty
        wait_c(1999);
        din = 16'h3C3C;
        din_valid = 1'b1;
        @(negedge clk96M);
        din_valid = 1'b0;
        chk("wrap_underrun", 32'(underrun), 32'd1);
        chk("wrap_ready", 32'(din_ready), 32'd0);
        capture_cur(left, right);
        chk("wrap_repeat", 32'(left), 32'h00002222);
        chk("wrap_ready_late", 32'(din_ready), 32'd0);
        capture_next(left, right, und);
        chk("wrap_sent_left", 32'(left), 32'h00003C3C);
        chk("wrap_sent_right", 32'(right), 32'h00003C3C);
        chk("wrap_sent_underrun", 32'(und), 32'd0);

        // reset mid-frame with a full buffer
        wait_c(600);
        send(16'h7777);
        wait_c(700);
        chk("pre_rst_mclk", 32'(mclk), 32'd1);
        chk("pre_rst_sdata", 32'(sdata), 32'd1);
        chk("pre_rst_ready", 32'(din_ready), 32'd0);
        @(posedge clk96M);
        #2 reset_n = 1'b0;
        #1;
        chk("async_mclk", 32'(mclk), 32'd0);
        chk("async_sdata", 32'(sdata), 32'd0);
        chk("async_bclk", 32'(bclk), 32'd0);
        chk("async_lrclk", 32'(lrclk), 32'd0);
        chk("async_flags", 32'({frame_tick, underrun}), 32'd0);
        chk("async_ready", 32'(din_ready), 32'd1);
        repeat (3) @(negedge clk96M);
        reset_n = 1'b1;
        capture_cur(left, right);
        chk("post_rst_left", 32'(left), 32'd0);
        chk("post_rst_right", 32'(right), 32'd0);
        capture_next(left, right, und);
        chk("post_rst_underrun", 32'(und), 32'd1);
        chk("post_rst_hold", 32'(left), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_codec_tx.md
Name: i2s_codec_tx

Overview:
- Downstream stage of the sine generator. Consumes the 16-bit signed sample stream (dout) and serialises it to the SSM2603 codec on the ZYBO as I2S master.
- Generates MCLK at 12 MHz (codec USB mode), BCLK at 1.92 MHz and LRCLK at 48 kHz, all from clk96M.
- The mono sample is sent on both channels.
- A 1-entry input buffer with valid/ready decouples the generator from frame timing and flags underruns.

Parameters:
- DW, 16, sample width (signed two's complement).
- CLKS_PER_FRAME, 2000, clk96M cycles per LRCLK frame (96 MHz / 48 kHz).
- BCLK_HALF, 25, clk96M cycles per BCLK half-period.
- SLOT_BITS, 20, BCLK periods per channel slot; must be ≥ DW+1. CLKS_PER_FRAME must equal 4*SLOT_BITS*BCLK_HALF.
- MCLK_HALF, 4, clk96M cycles per MCLK half-period.

Ports:
- clk96M, in, 1: system clock, 96 MHz.
- reset_n, in, 1: asynchronous, active-low reset.
- din, in, DW: sample from the generator.
- din_valid, in, 1: din holds a sample.
- din_ready, out, 1: buffer empty; the sample is accepted on an edge where din_valid && din_ready.
- mclk, out, 1: codec master clock.
- bclk, out, 1: I2S bit clock.
- lrclk, out, 1: word select; 0 = left, 1 = right.
- sdata, out, 1: I2S serial data.
- frame_tick, out, 1: one-cycle pulse when a new frame loads its sample.
- underrun, out, 1: one-cycle pulse when a frame loads with the buffer empty.

Behaviour:
- One clock, clk96M. Reset is asynchronous and active-low on reset_n. All outputs are registered.
- Reset values:
  - c (frame counter) = 0.
  - mclk = bclk = lrclk = sdata = 0.
  - Shift/hold register = 0; buffer empty.
  - din_ready = 1; frame_tick = underrun = 0.
- Counter c:
  - Runs 0..CLKS_PER_FRAME-1 and wraps.
  - Reset mid-frame aborts immediately; after release the frame restarts at c=0, the buffer is empty and the held sample is 0.
- Clock outputs are pure functions of c, updated on the edge where c takes its new value:
  - mclk = ((c / MCLK_HALF) mod 2).
  - bclk = ((c / BCLK_HALF) mod 2).
  - BCLK falls at c = 50k, with bit index k = 0..39.
- Bit timing at BCLK fall k:
  - lrclk = (k ≥ SLOT_BITS).
  - Slot position p = k mod SLOT_BITS.
  - sdata = hold[DW-p] for 1 ≤ p ≤ DW, otherwise 0. The MSB is therefore delayed one BCLK after the LRCLK edge (I2S standard), followed by zero padding.
  - Codec samples sdata on BCLK rising edges.
- Frame load, on the edge where c wraps to 0:
  - If the buffer is full: hold ← buffer, buffer emptied, frame_tick = 1.
  - If the buffer is empty: hold keeps the previous sample (repeat), frame_tick = 1, underrun = 1.
- Buffer:
  - din_ready = !buffer_full.
  - A write sets buffer_full.
  - Simultaneous write and load-when-full: load takes the old contents, the new sample is written, and the buffer stays full.
  - Simultaneous write and load-when-empty: underrun is flagged, the written sample stays in the buffer for the next frame, and din_ready = 0 next cycle.
- Right slot transmits the same hold value as the left slot. hold changes only at c=0.
- Latency: a sample accepted during frame N appears as the left MSB at BCLK fall k=1 of frame N+1 (c=50).

Decomposition:
- Package synth_audio_pkg:
  - typedef sample_t = logic signed [15:0].
  - Constants CLKS_PER_FRAME, BCLK_HALF, SLOT_BITS, MCLK_HALF.
- Sub-module i2s_clkgen: frame counter c plus mclk, bclk, lrclk, bclk-fall strobe, bit index k and frame-start strobe.
- The top level holds the buffer, hold register, sdata mux and flags.

Test Plan:
- Reset, then no din_valid for 3 frames:
  - mclk period 8 cycles; bclk period 50; lrclk period 2000, high for c 1000..1999.
  - sdata always 0; underrun pulses at each c=0.
- din=16'hA5C3 held valid, accepted in frame 0:
  - Frame 1 left bits k=1..16 read 1010010111000011; k=17..19 are 0.
  - Right bits k=21..36 carry the same pattern.
- Single sample 16'h8001, then none:
  - Frame 1 sends 8001 with underrun=0.
  - Frame 2 repeats 8001 with underrun=1.
- Two back-to-back writes 0x1111, 0x2222 in one frame:
  - Second is stalled with din_ready=0 until c=0.
  - Frames send 1111 then 2222.
- din_valid asserted on the wrap edge with the buffer empty:
  - underrun=1 and hold unchanged; sample sent the following frame; din_ready=0 for one frame.
- reset_n low at c=700 for 3 cycles:
  - All outputs go to 0 asynchronously.
  - After release bclk restarts at c=0 and the buffer is empty.
